mem_port_arbiter: RTL and testbench

//  Shares the single-port data memory used by the ME stage between two requesters:
//  the IF fetch port (read-only) and the ME load/store port. Fixed priority to ME, with
//  a starvation guard so IF is served after STARVE_MAX back-to-back ME wins. Sequences

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data memory between the IF fetch port and the ME load/store port
// Ports: clk_i/rst_ni clock and async active-low reset; if_* fetch request/ack/data;
// me_* load/store request/ack/data; stall_*_o combinational pipeline stalls;
// mem_addr_o/mem_wen_o/mem_din_o registered memory controls; mem_dout_i memory read data.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              me_req_i,
  input  logic              me_wen_i,
  input  logic [ADDR_W-1:0] me_addr_i,
  input  logic [DATA_W-1:0] me_wdata_i,
  output logic              me_ack_o,
  output logic [DATA_W-1:0] me_rdata_o,
  output logic              stall_if_o,
  output logic              stall_me_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wen_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, store_q, store_d;
  logic [3:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic if_ack_q, if_ack_d, me_ack_q, me_ack_d, mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, me_rdata_q, me_rdata_d, mem_din_q, mem_din_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic grant_me, starved;
  assign starved  = if_req_i & (starve_q == SW'(STARVE_MAX));
  assign grant_me = me_req_i & ~starved;
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    store_d    = store_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    if_ack_d   = 1'b0;
    me_ack_d   = 1'b0;
    mem_wen_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    me_rdata_d = me_rdata_q;
    mem_din_d  = mem_din_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (if_req_i | me_req_i) begin
        owner_d    = grant_me;
        store_d    = grant_me & me_wen_i;
        mem_wen_d  = grant_me & me_wen_i;
        mem_addr_d = grant_me ? me_addr_i : if_addr_i;
        mem_din_d  = grant_me ? me_wdata_i : mem_din_q;
        cnt_d      = 4'(MEM_LAT);
        starve_d   = (grant_me & if_req_i) ? (starved ? starve_q : starve_q + 1'b1) : '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          me_ack_d   = owner_q;
          if_ack_d   = ~owner_q;
          me_rdata_d = (owner_q & ~store_q) ? mem_dout_i : me_rdata_q;
          if_rdata_d = ~owner_q ? mem_dout_i : if_rdata_q;
          state_d    = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      store_q    <= 1'b0;
      cnt_q      <= '0;
      starve_q   <= '0;
      if_ack_q   <= 1'b0;
      me_ack_q   <= 1'b0;
      mem_wen_q  <= 1'b0;
      if_rdata_q <= '0;
      me_rdata_q <= '0;
      mem_din_q  <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      store_q    <= store_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      if_ack_q   <= if_ack_d;
      me_ack_q   <= me_ack_d;
      mem_wen_q  <= mem_wen_d;
      if_rdata_q <= if_rdata_d;
      me_rdata_q <= me_rdata_d;
      mem_din_q  <= mem_din_d;
      mem_addr_q <= mem_addr_d;
    end
  end
  assign if_ack_o   = if_ack_q;
  assign me_ack_o   = me_ack_q;
  assign if_rdata_o = if_rdata_q;
  assign me_rdata_o = me_rdata_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wen_o  = mem_wen_q;
  assign mem_din_o  = mem_din_q;
  assign stall_if_o = if_req_i & ~if_ack_q;
  assign stall_me_o = me_req_i & ~me_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors and corner sequences for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic if_req, me_req, me_wen;
  logic [31:0] if_addr, me_addr, me_wdata;
  logic a_if_ack, a_me_ack, a_stall_if, a_stall_me, a_mem_wen;
  logic [31:0] a_if_rdata, a_me_rdata, a_mem_addr, a_mem_din, a_dout;
  logic b_if_ack, b_me_ack, b_stall_if, b_stall_me, b_mem_wen;
  logic [31:0] b_if_rdata, b_me_rdata, b_mem_addr, b_mem_din, b_dout;
  logic [31:0] mem [256];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (a_mem_wen) mem[a_mem_addr[9:2]] <= a_mem_din;
  assign a_dout = mem[a_mem_addr[9:2]];
  assign b_dout = mem[b_mem_addr[9:2]];
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(a_if_ack), .if_rdata_o(a_if_rdata),
    .me_req_i(me_req), .me_wen_i(me_wen), .me_addr_i(me_addr), .me_wdata_i(me_wdata),
    .me_ack_o(a_me_ack), .me_rdata_o(a_me_rdata),
    .stall_if_o(a_stall_if), .stall_me_o(a_stall_me),
    .mem_addr_o(a_mem_addr), .mem_wen_o(a_mem_wen), .mem_din_o(a_mem_din), .mem_dout_i(a_dout));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(b_if_ack), .if_rdata_o(b_if_rdata),
    .me_req_i(me_req), .me_wen_i(me_wen), .me_addr_i(me_addr), .me_wdata_i(me_wdata),
    .me_ack_o(b_me_ack), .me_rdata_o(b_me_rdata),
    .stall_if_o(b_stall_if), .stall_me_o(b_stall_me),
    .mem_addr_o(b_mem_addr), .mem_wen_o(b_mem_wen), .mem_din_o(b_mem_din), .mem_dout_i(b_dout));

  typedef struct {
    logic        is_me;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_me;
    int          exp_wen;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // exp bit i = 1 when the i-th ack must go to ME, 0 when it must go to IF
  task automatic check_order(input int n, input logic [7:0] exp);
    for (int i = 0; i < n; i++) begin
      int cyc = 0;
      do begin step(); cyc++; end while (!(a_if_ack | a_me_ack) && cyc < 10);
      chk($sformatf("order[%0d]", i), {a_if_ack, a_me_ack}, exp[i] ? 2'b01 : 2'b10);
    end
  endtask

  initial begin
    int lat, wen_n, cyc;
    logic ack;
    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h2402000A, 32'h0,        0};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h2402000A, 32'h0,        1};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h2402000A, 32'hDEADBEEF, 0};
    vecs[3] = '{1'b1, 1'b1, 32'h104, 32'h12345678, 32'h2402000A, 32'hDEADBEEF, 1};
    vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'h12345678, 32'hDEADBEEF, 0};
    vecs[5] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'h12345678, 32'h2402000A, 0};
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h40;
    me_req = 1'b1; me_wen = 1'b1; me_addr = 32'h40; me_wdata = 32'h2402000A;
    repeat (2) step();
    chk("rst if_ack", a_if_ack, 0);
    chk("rst me_ack", a_me_ack, 0);
    chk("rst mem_wen", a_mem_wen, 0);
    chk("rst mem_addr", a_mem_addr, 0);
    chk("rst mem_din", a_mem_din, 0);
    chk("rst rdata", {a_if_rdata, a_me_rdata}, 0);
    rst_n = 1'b1;
    step();
    chk("post-rst grant addr", a_mem_addr, 32'h40);
    chk("post-rst grant wen", a_mem_wen, 1);
    if_req = 1'b0; me_req = 1'b0;
    step();
    chk("dropped req ack", a_me_ack, 1);
    chk("store keeps me_rdata", a_me_rdata, 0);
    step();
    for (int v = 0; v < 6; v++) begin
      step();
      if_req = !vecs[v].is_me; me_req = vecs[v].is_me; me_wen = vecs[v].wen;
      if_addr = vecs[v].addr; me_addr = vecs[v].addr; me_wdata = vecs[v].wdata;
      #1;
      chk($sformatf("v%0d stall", v), {a_stall_if, a_stall_me}, {!vecs[v].is_me, vecs[v].is_me});
      lat = 0; wen_n = 0; ack = 1'b0;
      while (!ack && lat < 10) begin
        step(); lat++;
        wen_n += int'(a_mem_wen);
        ack = vecs[v].is_me ? a_me_ack : a_if_ack;
      end
      chk($sformatf("v%0d latency", v), lat, 2);
      chk($sformatf("v%0d wen cycles", v), wen_n, vecs[v].exp_wen);
      chk($sformatf("v%0d if_rdata", v), a_if_rdata, vecs[v].exp_if);
      chk($sformatf("v%0d me_rdata", v), a_me_rdata, vecs[v].exp_me);
      chk($sformatf("v%0d other ack", v), vecs[v].is_me ? a_if_ack : a_me_ack, 0);
      chk($sformatf("v%0d stall at ack", v), {a_stall_if, a_stall_me}, 0);
      if_req = 1'b0; me_req = 1'b0;
    end
    step();
    if_req = 1'b1; if_addr = 32'h40; me_req = 1'b1; me_wen = 1'b0; me_addr = 32'h100;
    check_order(6, 8'b0001_1011);
    chk("if fetch data in arb", a_if_rdata, 32'h2402000A);
    if_req = 1'b0; me_req = 1'b0;
    step();
    me_req = 1'b1; me_wen = 1'b1; me_addr = 32'h108; me_wdata = 32'hCAFEF00D; if_req = 1'b1;
    step();
    chk("abort store wen", a_mem_wen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort wen drops", a_mem_wen, 0);
    chk("abort addr clr", a_mem_addr, 0);
    step();
    chk("abort no ack", a_me_ack, 0);
    rst_n = 1'b1;
    check_order(3, 8'b0000_0011);
    if_req = 1'b0; me_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    me_req = 1'b1; me_wen = 1'b0; me_addr = 32'h40;
    cyc = 0;
    do begin step(); cyc++; end while (!b_me_ack && cyc < 20);
    chk("lat3 ack latency", cyc, 4);
    chk("lat3 rdata", b_me_rdata, 32'h2402000A);
    cyc = 0;
    do begin step(); cyc++; end while (!b_me_ack && cyc < 20);
    chk("lat3 ack spacing", cyc, 5);
    me_req = 1'b0;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
